// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative
// RV32M multiply/divide unit (mdu_iter) and its divide-step helper.
package mdu_pkg;

    localparam int XLEN = 32;
    localparam int ITER = XLEN;

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] DIV0_Q = '1;
    localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

    // funct3[2] selects the divide half of RV32M
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // funct3[1] selects a remainder among the divide ops
    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request / write-back bundle between the pipeline and mdu_iter.
// Ports: start_i, op_i, rs1_i, rs2_i, rd_i (request); busy_o, done_o,
// result_o, rd_o, we_o (status and register-file write port).
interface mdu_iter_if;
    import mdu_pkg::*;

    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic            we_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, rd_i,
        input  busy_o, done_o, result_o, rd_o, we_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, rd_i,
        output busy_o, done_o, result_o, rd_o, we_o
    );

endinterface

// File: rtl/mdu_divstep.sv
// One combinational restoring-divide step.
// Ports: rem_i/quo_i (partial remainder, dividend/quotient shift reg),
// div_i (divisor); rem_o/quo_o (state after the step).
module mdu_divstep
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          fits;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign trial   = shifted - {1'b0, div_i};
    // rem < divisor keeps a successful trial below 2^XLEN, so the top
    // bit is a clean borrow flag.
    assign fits    = ~trial[XLEN];

    assign rem_o = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or
// restoring divide on operand magnitudes, sign fixed at finalisation.
// Ports: clk, reset (async, active-high), bus (slave side of mdu_iter_if:
// start/op/rs1/rs2/rd in, busy/done/result/rd/we out).
module mdu_iter
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mdu_iter_if.slave  bus
);

    state_t            state_q;
    logic [4:0]        cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic              neg_q;
    logic              spec_q;
    logic [XLEN-1:0]   spec_val_q;
    logic              busy_q;
    logic              done_q;
    logic              we_q;
    logic [XLEN-1:0]   res_q;
    logic [4:0]        rdo_q;

    // capture-time decode
    logic              sg1;
    logic              sg2;
    logic              s1;
    logic              s2;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              neg_c;
    logic              div0_c;
    logic              ovf_c;
    logic [XLEN-1:0]   spec_val_c;

    always_comb begin
        sg1 = 1'b0;
        sg2 = 1'b0;
        unique case (bus.op_i)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sg1 = 1'b1;
                sg2 = 1'b1;
            end
            OP_MULHSU: sg1 = 1'b1;
            default: ;
        endcase
    end

    assign s1   = sg1 & bus.rs1_i[XLEN-1];
    assign s2   = sg2 & bus.rs2_i[XLEN-1];
    assign mag1 = s1 ? (~bus.rs1_i + 1'b1) : bus.rs1_i;
    assign mag2 = s2 ? (~bus.rs2_i + 1'b1) : bus.rs2_i;

    // remainder follows the dividend sign; everything else the xor
    assign neg_c = is_rem(bus.op_i) ? s1 : (s1 ^ s2);

    assign div0_c = is_div(bus.op_i) & (bus.rs2_i == '0);
    assign ovf_c  = ((bus.op_i == OP_DIV) | (bus.op_i == OP_REM))
                  & (bus.rs1_i == OVF_Q) & (bus.rs2_i == '1);

    always_comb begin
        spec_val_c = '0;
        if (div0_c) begin
            spec_val_c = bus.op_i[1] ? bus.rs1_i : DIV0_Q;
        end else if (ovf_c) begin
            spec_val_c = bus.op_i[1] ? '0 : OVF_Q;
        end
    end

    // iteration datapath
    logic [XLEN-1:0]   rem_n;
    logic [XLEN-1:0]   quo_n;
    logic [XLEN:0]     madd;
    logic [2*XLEN-1:0] mul_n;
    logic [2*XLEN-1:0] acc_d;

    mdu_divstep u_divstep (
        .rem_i (acc_q[2*XLEN-1:XLEN]),
        .quo_i (acc_q[XLEN-1:0]),
        .div_i (opb_q),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    // multiplier sits in the low half and shifts out as the product
    // grows into the high half
    assign madd  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_n = {madd, acc_q[XLEN-1:1]};
    assign acc_d = is_div(op_q) ? {rem_n, quo_n} : mul_n;

    // finalisation
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   dsel;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   res_d;

    assign prod    = neg_q ? (~acc_d + 1'b1) : acc_d;
    assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0]
                                      : prod[2*XLEN-1:XLEN];
    assign dsel    = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
    assign div_res = neg_q ? (~dsel + 1'b1) : dsel;
    assign res_d   = spec_q ? spec_val_q
                   : (is_div(op_q) ? div_res : mul_res);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            res_q      <= '0;
            rdo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        op_q       <= bus.op_i;
                        rd_q       <= bus.rd_i;
                        acc_q      <= {{XLEN{1'b0}}, mag1};
                        opb_q      <= mag2;
                        neg_q      <= neg_c;
                        spec_q     <= div0_c | ovf_c;
                        spec_val_q <= spec_val_c;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == 5'(ITER - 1)) begin
                        res_q   <= res_d;
                        rdo_q   <= rd_q;
                        done_q  <= 1'b1;
                        we_q    <= (rd_q != '0);
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.we_o     = we_q;
    assign bus.result_o = res_q;
    assign bus.rd_o     = rdo_q;

endmodule
